// File: rtl/ser_pkg.sv
// Shared types and width helpers for the word serializer.
package ser_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } ser_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Clearable up-counter that saturates at TERM and flags the terminal count.
module ser_bit_counter #(
  parameter int unsigned W    = 2,
  parameter int unsigned TERM = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic at_term
);

  logic [W-1:0] count;

  assign at_term = (count == W'(TERM));

  // Clear wins over increment; no wrap past the terminal value.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !at_term) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/piso_word_serializer.sv
// Parallel-in/serial-out word serializer feeding a downstream serial-in shift register.
module piso_word_serializer
  import ser_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MSB_FIRST = 1,
  parameter int unsigned IDLE_GAP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             serial_out,
  output logic             shift_en,
  output logic             frame_done,
  output logic             busy
);

  localparam int unsigned BIT_W    = cnt_w(WIDTH);
  localparam int unsigned GAP_W    = cnt_w(IDLE_GAP + 1);
  localparam int unsigned GAP_TERM = (IDLE_GAP > 0) ? IDLE_GAP - 1 : 0;

  ser_state_e       state;
  ser_state_e       state_d;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_d;
  logic             armed;
  logic             accept;
  logic             tx_bit;
  logic             bit_clear;
  logic             bit_inc;
  logic             bit_last;
  logic             gap_clear;
  logic             gap_inc;
  logic             gap_last;

  // armed keeps in_ready low until the first cycle after reset is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      armed <= 1'b0;
    end else begin
      state <= state_d;
      shreg <= shreg_d;
      armed <= 1'b1;
    end
  end

  assign tx_bit = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];

  always_comb begin
    in_ready   = 1'b0;
    shift_en   = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    serial_out = 1'b0;
    state_d    = state;
    shreg_d    = shreg;
    bit_clear  = 1'b0;
    bit_inc    = 1'b0;
    gap_clear  = 1'b0;
    gap_inc    = 1'b0;
    accept     = 1'b0;

    case (state)
      IDLE: begin
        in_ready = armed;
      end
      SHIFT: begin
        shift_en   = 1'b1;
        busy       = 1'b1;
        serial_out = tx_bit;
        bit_inc    = 1'b1;
        shreg_d    = (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0}
                                      : {1'b0, shreg[WIDTH-1:1]};
        if (bit_last) begin
          frame_done = 1'b1;
          if (IDLE_GAP == 0) begin
            // Back-to-back mode: a new word may load in the last bit cycle.
            in_ready = armed;
            state_d  = IDLE;
          end else begin
            gap_clear = 1'b1;
            state_d   = GAP;
          end
        end
      end
      GAP: begin
        busy    = 1'b1;
        gap_inc = 1'b1;
        if (gap_last) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    accept = in_valid && in_ready;
    if (accept) begin
      shreg_d   = in_data;
      bit_clear = 1'b1;
      state_d   = SHIFT;
    end
  end

  ser_bit_counter #(
    .W    (BIT_W),
    .TERM (WIDTH - 1)
  ) u_bit_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (bit_clear),
    .inc     (bit_inc),
    .at_term (bit_last)
  );

  ser_bit_counter #(
    .W    (GAP_W),
    .TERM (GAP_TERM)
  ) u_gap_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (gap_clear),
    .inc     (gap_inc),
    .at_term (gap_last)
  );

endmodule
